// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing for the truth-table sweeper.
package truth_table_sweeper_pkg;

  localparam int unsigned NUM_VECTORS = 32;
  localparam int unsigned VEC_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : truth_table_sweeper_pkg

// File: rtl/truth_table_sweeper_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and pulses tc on the last
// count, so the owner knows when to sample and advance to the next vector.
module sweep_dwell_timer #(
  parameter int unsigned DWELL = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  logic [7:0] cnt;

  // Free-running dwell count, wrapping at LAST; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
    end
  end

  // With DWELL=1 the count sits at 0 and tc fires on every enabled cycle.
  assign tc = enable && !clear && (cnt == LAST);

endmodule : sweep_dwell_timer

// File: rtl/truth_table_sweeper.sv
// Drives all 32 five-input vectors into a combinational circuit, holds each
// for DWELL cycles, samples the response at the end of each dwell and compares
// it against a golden truth table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned DWELL = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_VECTORS-1:0] expected,
  input  logic                   y,
  output logic [VEC_W-1:0]       vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] table_out,
  output logic [5:0]             mismatch_cnt,
  output logic [VEC_W-1:0]       first_fail,
  output logic                   first_fail_valid
);

  state_t state_q;
  state_t state_d;

  logic sample;
  logic last_vec;
  logic start_sweep;
  logic running;

  assign running     = (state_q == ST_RUN);
  // start is only honoured outside RUN; abort is only honoured inside RUN.
  assign start_sweep = start && !running;
  assign last_vec    = (vec == VEC_W'(NUM_VECTORS - 1));

  sweep_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!running || abort),
    .enable (running),
    .tc     (sample)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort beats both completion and start inside RUN.
  always_comb begin
    // NOTE: assigning the default first guarantees every path drives state_d,
    // so no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (abort)                  state_d = ST_IDLE;
        else if (sample && last_vec) state_d = ST_DONE;
      end
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Vector stepping and result capture; results survive abort until next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec              <= '0;
      table_out        <= '0;
      mismatch_cnt     <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else if (start_sweep) begin
      vec              <= '0;
      table_out        <= '0;
      mismatch_cnt     <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else if (running) begin
      if (abort) begin
        vec <= '0;
      end else if (sample) begin
        table_out[vec] <= y;
        if (y != expected[vec]) begin
          mismatch_cnt <= mismatch_cnt + 6'd1;
          if (!first_fail_valid) begin
            first_fail       <= vec;
            first_fail_valid <= 1'b1;
          end
        end
        // The sweep ends at vector 31; the return to 0 coincides with DONE.
        vec <= last_vec ? '0 : vec + VEC_W'(1);
      end
    end
  end

  assign busy = running;
  assign done = (state_q == ST_DONE);
  assign pass = done && (mismatch_cnt == 6'd0);

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance at DWELL=4 and one at
// DWELL=1, each fed by a simple circuit-under-test model built from vec bits.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start, abort;
  logic [31:0] expected;
  logic        y_en;
  logic        y;
  logic [4:0]  vec;
  logic        busy, done, pass, ffv;
  logic [31:0] table_out;
  logic [5:0]  mismatch_cnt;
  logic [4:0]  first_fail;

  logic        start1;
  logic [31:0] expected1;
  logic        y1;
  logic [4:0]  vec1;
  logic        busy1, done1, pass1, ffv1;
  logic [31:0] table_out1;
  logic [5:0]  mismatch_cnt1;
  logic [4:0]  first_fail1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Circuit under test models: Y = E (or 0) for dut, Y = A for dut1.
  assign y  = y_en & vec[0];
  assign y1 = vec1[4];

  truth_table_sweeper #(.DWELL(4)) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
    .expected (expected), .y (y), .vec (vec), .busy (busy), .done (done),
    .pass (pass), .table_out (table_out), .mismatch_cnt (mismatch_cnt),
    .first_fail (first_fail), .first_fail_valid (ffv)
  );

  truth_table_sweeper #(.DWELL(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .start (start1), .abort (1'b0),
    .expected (expected1), .y (y1), .vec (vec1), .busy (busy1), .done (done1),
    .pass (pass1), .table_out (table_out1), .mismatch_cnt (mismatch_cnt1),
    .first_fail (first_fail1), .first_fail_valid (ffv1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = '0; y_en = 1'b0;
    start1 = 1'b0; expected1 = 32'hFFFF_0000;
    tick(2);
    check("rst_vec",  {27'd0, vec}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    #2 rst_n = 1'b1;
    tick(1);

    // Sweep 1: y tied low, expected all zero.
    start = 1'b1;            // edge t is the one just passed
    tick(1);                 // t+1
    start = 1'b0;
    check("s1_busy",     {31'd0, busy}, 32'd1);
    check("s1_vec0",     {27'd0, vec}, 32'd0);
    check("s1_pass_run", {31'd0, pass}, 32'd0);
    tick(127);               // t+128
    check("s1_done_early", {31'd0, done}, 32'd0);
    check("s1_vec31",      {27'd0, vec}, 32'd31);
    tick(1);                 // t+129
    check("s1_done",  {31'd0, done}, 32'd1);
    check("s1_busy0", {31'd0, busy}, 32'd0);
    check("s1_pass",  {31'd0, pass}, 32'd1);
    check("s1_table", table_out, 32'd0);
    check("s1_mcnt",  {26'd0, mismatch_cnt}, 32'd0);
    check("s1_vecd",  {27'd0, vec}, 32'd0);

    // Sweep 2: y = E, golden matches.
    y_en = 1'b1; expected = 32'hAAAA_AAAA;
    start = 1'b1; tick(1); start = 1'b0;
    check("s2_done_clr", {31'd0, done}, 32'd0);
    tick(128);
    check("s2_done",  {31'd0, done}, 32'd1);
    check("s2_table", table_out, 32'hAAAA_AAAA);
    check("s2_pass",  {31'd0, pass}, 32'd1);
    check("s2_ffv",   {31'd0, ffv}, 32'd0);

    // Sweep 3: golden differs on vector 0 only.
    expected = 32'hAAAA_AAAB;
    start = 1'b1; tick(1); start = 1'b0;
    check("s3_tbl_clr", table_out, 32'd0);
    tick(128);
    check("s3_done", {31'd0, done}, 32'd1);
    check("s3_mcnt", {26'd0, mismatch_cnt}, 32'd1);
    check("s3_ff",   {27'd0, first_fail}, 32'd0);
    check("s3_ffv",  {31'd0, ffv}, 32'd1);
    check("s3_pass", {31'd0, pass}, 32'd0);

    // Sweep 4: abort (with a simultaneous start) during vector 10.
    expected = 32'hAAAA_AAAA;
    start = 1'b1; tick(1); start = 1'b0;
    tick(40);                // t+41: first cycle of vector 10
    check("s4_vec10", {27'd0, vec}, 32'd10);
    abort = 1'b1; start = 1'b1;
    tick(1);
    abort = 1'b0; start = 1'b0;
    check("s4_busy", {31'd0, busy}, 32'd0);
    check("s4_vec",  {27'd0, vec}, 32'd0);
    check("s4_done", {31'd0, done}, 32'd0);
    check("s4_table", table_out, 32'h0000_02AA);
    abort = 1'b1; tick(2); abort = 1'b0;  // abort in IDLE does nothing
    check("s4_idle_busy",  {31'd0, busy}, 32'd0);
    check("s4_idle_table", table_out, 32'h0000_02AA);

    // Sweep 5: start held through RUN, then async reset during vector 20.
    start = 1'b1; tick(1);
    tick(80);                // t+81: first cycle of vector 20
    check("s5_vec20", {27'd0, vec}, 32'd20);
    tick(2);
    check("s5_vec20_hold", {27'd0, vec}, 32'd20);
    check("s5_busy_hold",  {31'd0, busy}, 32'd1);
    start = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("s5_rst_vec",   {27'd0, vec}, 32'd0);
    check("s5_rst_busy",  {31'd0, busy}, 32'd0);
    check("s5_rst_table", table_out, 32'd0);
    check("s5_rst_ffv",   {31'd0, ffv}, 32'd0);
    #1 rst_n = 1'b1;
    tick(3);
    check("s5_wait_busy", {31'd0, busy}, 32'd0);
    check("s5_wait_vec",  {27'd0, vec}, 32'd0);

    // Sweep 6: DWELL=1 instance, y = A.
    start1 = 1'b1; tick(1); start1 = 1'b0;  // t+1
    check("d1_vec0", {27'd0, vec1}, 32'd0);
    tick(1);
    check("d1_vec1", {27'd0, vec1}, 32'd1);
    tick(1);
    check("d1_vec2", {27'd0, vec1}, 32'd2);
    tick(29);                // t+32
    check("d1_vec31",      {27'd0, vec1}, 32'd31);
    check("d1_done_early", {31'd0, done1}, 32'd0);
    tick(1);                 // t+33
    check("d1_done",  {31'd0, done1}, 32'd1);
    check("d1_table", table_out1, 32'hFFFF_0000);
    check("d1_pass",  {31'd0, pass1}, 32'd1);
    check("d1_busy",  {31'd0, busy1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_truth_table_sweeper

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have parameter DWELL, default 20, meaning clock cycles each input vector is held; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, begin a sweep; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port abort, input, 1, cancel a sweep in progress.
REQ-006 The block SHALL have port expected, input, 32, golden truth table; bit k is the expected Y for vector k.
REQ-007 The block SHALL have port y, input, 1, combinational response of the circuit under test.
REQ-008 The block SHALL have port vec, output, 5, stimulus {A,B,C,D,E}, A = bit 4 (MSB), E = bit 0.
REQ-009 The block SHALL have port busy, output, 1, high while a sweep runs.
REQ-010 The block SHALL have port done, output, 1, level; high from sweep completion until the next start.
REQ-011 The block SHALL have port pass, output, 1, high only when done=1 and mismatch_cnt=0.
REQ-012 The block SHALL have port table_out, output, 32, captured Y per vector.
REQ-013 The block SHALL have port mismatch_cnt, output, 6, number of vectors with y != expected (0..32).
REQ-014 The block SHALL have port first_fail, output, 5, lowest failing vector index; first_fail_valid, output, 1, high once any failure is seen.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 On start=1 in IDLE or DONE, the next edge SHALL enter RUN; vec=0; dwell counter=0; and table_out, mismatch_cnt, first_fail, first_fail_valid and done SHALL clear.
REQ-017 Timing: with start seen at edge t, vector k SHALL be driven for exactly DWELL cycles, from edge t+1+k*DWELL.
REQ-018 Sampling: y SHALL be sampled on the last cycle of each dwell (counter = DWELL-1).
  - table_out[k] SHALL be written with y.
  - On mismatch, mismatch_cnt SHALL increment.
  - On mismatch, if first_fail_valid=0, first_fail SHALL be set to k and first_fail_valid to 1.
REQ-019 After the sample of vector 31, the next edge SHALL enter DONE with done=1 and vec=0; done SHALL first be high at edge t+1+32*DWELL.
REQ-020 Vector advance: the vector SHALL advance by +1 only; it SHALL never wrap from 31 to 0 inside RUN.
REQ-021 start while in RUN SHALL be ignored.
REQ-022 abort in RUN SHALL enter IDLE on the next edge with busy=0, done=0 and vec=0; partial results SHALL be held.
  - abort and start on the same cycle: abort SHALL win.
  - abort outside RUN SHALL have no effect.
REQ-023 With DWELL=1, every cycle SHALL be both a drive cycle and a sample cycle.
REQ-024 busy SHALL equal (state==RUN); pass SHALL be combinational from done and mismatch_cnt.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, and all of the following to 0: vec, busy, done, table_out, mismatch_cnt, first_fail, first_fail_valid, and the dwell counter.
REQ-026 Reset mid-sweep SHALL discard the sweep; after release the block SHALL wait for a new start.

Structure
REQ-027 A shared package SHALL hold the state enum, NUM_VECTORS=32 and VEC_W=5.
REQ-028 The dwell counter SHALL be a sub-module sweep_dwell_timer.
  - Parameter: DWELL.
  - Inputs: clear and enable.
  - Output: a terminal-count pulse.

Verification (DWELL=4 unless stated)
REQ-029 y tied 0, expected=32'h0, start pulse -> done high at t+129, pass=1, table_out=0, mismatch_cnt=0.
REQ-030 y=vec[0], expected=32'hAAAAAAAA -> table_out=32'hAAAAAAAA, pass=1, first_fail_valid=0.
REQ-031 y=vec[0], expected=32'hAAAAAAAB -> mismatch_cnt=1, first_fail=0, first_fail_valid=1, pass=0.
REQ-032 abort while vec=10 -> next edge busy=0, vec=0, done=0; table_out bits 0..9 retained.
REQ-033 rst_n low while vec=20 -> all outputs 0 immediately; start held high through RUN has no effect.
REQ-034 DWELL=1, y=vec[4] -> vec increments every cycle; done at t+33; table_out=32'hFFFF0000.
